// File: rtl/csr_rmw_seq_if.sv
// Bundle of request, CSR-bus and writeback signals for csr_rmw_seq.
// master: the sequencer side; slave: decode / CSR file / writeback side.
interface csr_rmw_seq_if #(
  parameter int XLEN = 32
);
  logic            req_valid;
  logic            req_ready;
  logic [2:0]      req_funct3;
  logic [11:0]     req_addr;
  logic [XLEN-1:0] req_rs1;
  logic [4:0]      req_zimm;
  logic [4:0]      req_rd;

  logic            csr_rd_en;
  logic            csr_wr_en;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_rvalid;
  logic            csr_wready;

  logic            wb_valid;
  logic            wb_ready;
  logic [4:0]      wb_rd;
  logic [XLEN-1:0] wb_data;
  logic            wb_illegal;
  logic            wb_buserr;

  modport master (
    input  req_valid, req_funct3, req_addr, req_rs1, req_zimm, req_rd,
    input  csr_rdata, csr_rvalid, csr_wready, wb_ready,
    output req_ready, csr_rd_en, csr_wr_en, csr_addr, csr_wdata,
    output wb_valid, wb_rd, wb_data, wb_illegal, wb_buserr
  );

  modport slave (
    output req_valid, req_funct3, req_addr, req_rs1, req_zimm, req_rd,
    output csr_rdata, csr_rvalid, csr_wready, wb_ready,
    input  req_ready, csr_rd_en, csr_wr_en, csr_addr, csr_wdata,
    input  wb_valid, wb_rd, wb_data, wb_illegal, wb_buserr
  );
endinterface

// File: rtl/csr_rmw_seq.sv
// Zicsr read-modify-write sequencer: IDLE -> READ -> WRITE -> WB on the CSR bus.
// Optional feature macro: CSR_RDONLY_CHECK_EN (reject writes to addr[11:10]==2'b11).
module csr_rmw_seq #(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input logic           clk,
  input logic           rst_n,
  csr_rmw_seq_if.master bus
);
  localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, READ, WRITE, WB} state_t;
  typedef enum logic [1:0] {OP_ILL = 2'b00, OP_RW = 2'b01, OP_RS = 2'b10, OP_RC = 2'b11} op_t;

  state_t          state;
  op_t             op;
  logic [XLEN-1:0] src;
  logic            do_write;
  logic [CW-1:0]   wait_cnt;
  logic            rd_en, wr_en, wb_valid, wb_illegal, wb_buserr;
  logic [11:0]     addr;
  logic [XLEN-1:0] wdata, wb_data;
  logic [4:0]      wb_rd;

  op_t             in_op;
  logic [XLEN-1:0] in_src;
  logic            in_read, in_write, in_ro_fault;

  always_comb begin
    in_op    = op_t'(bus.req_funct3[1:0]);
    in_src   = bus.req_funct3[2] ? XLEN'(bus.req_zimm) : bus.req_rs1;
    in_read  = !(in_op == OP_RW && bus.req_rd == 5'd0);
    in_write = (in_op == OP_RW) || (in_src != '0);
`ifdef CSR_RDONLY_CHECK_EN
    in_ro_fault = (bus.req_addr[11:10] == 2'b11) && in_write;
`else
    in_ro_fault = 1'b0;
`endif
  end

  // A skipped read is treated as old == 0 when merging.
  function automatic logic [XLEN-1:0] merge(input op_t o, input logic [XLEN-1:0] old,
                                            input logic [XLEN-1:0] s);
    case (o)
      OP_RS:   return old | s;
      OP_RC:   return old & ~s;
      default: return s;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op         <= OP_ILL;
      src        <= '0;
      do_write   <= 1'b0;
      wait_cnt   <= '0;
      rd_en      <= 1'b0;
      wr_en      <= 1'b0;
      wb_valid   <= 1'b0;
      wb_illegal <= 1'b0;
      wb_buserr  <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          addr       <= bus.req_addr;
          wb_rd      <= bus.req_rd;
          op         <= in_op;
          src        <= in_src;
          do_write   <= in_write;
          wait_cnt   <= '0;
          wb_illegal <= 1'b0;
          wb_buserr  <= 1'b0;
          wb_data    <= '0;
          if (in_op == OP_ILL || in_ro_fault) begin
            state      <= WB;
            wb_valid   <= 1'b1;
            wb_illegal <= 1'b1;
          end else if (in_read) begin
            state <= READ;
            rd_en <= 1'b1;
          end else begin
            state <= WRITE;
            wr_en <= 1'b1;
            wdata <= merge(in_op, '0, in_src);
          end
        end
        READ: if (bus.csr_rvalid) begin
          rd_en    <= 1'b0;
          wait_cnt <= '0;
          wb_data  <= bus.csr_rdata;
          if (do_write) begin
            state <= WRITE;
            wr_en <= 1'b1;
            wdata <= merge(op, bus.csr_rdata, src);
          end else begin
            state    <= WB;
            wb_valid <= 1'b1;
          end
        end else if (wait_cnt == LAST_WAIT) begin
          rd_en     <= 1'b0;
          state     <= WB;
          wb_valid  <= 1'b1;
          wb_buserr <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
        // A timed-out write is dropped, never retried.
        WRITE: if (bus.csr_wready) begin
          wr_en    <= 1'b0;
          state    <= WB;
          wb_valid <= 1'b1;
        end else if (wait_cnt == LAST_WAIT) begin
          wr_en     <= 1'b0;
          state     <= WB;
          wb_valid  <= 1'b1;
          wb_buserr <= 1'b1;
          wb_data   <= '0;
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
        WB: if (bus.wb_ready) begin
          wb_valid <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.csr_rd_en  = rd_en;
  assign bus.csr_wr_en  = wr_en;
  assign bus.csr_addr   = addr;
  assign bus.csr_wdata  = wdata;
  assign bus.wb_valid   = wb_valid;
  assign bus.wb_rd      = wb_rd;
  assign bus.wb_data    = wb_data;
  assign bus.wb_illegal = wb_illegal;
  assign bus.wb_buserr  = wb_buserr;
endmodule

// File: tb/tb_csr_rmw_seq.sv
// Randomized bench for csr_rmw_seq: a CSR-file/bus responder plus a per-instruction
// reference model that predicts result, bus activity, write data and latency.
module tb_csr_rmw_seq;
  localparam int XLEN = 32;
  localparam int TO   = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csr_rmw_seq_if #(.XLEN(XLEN)) bus();

  csr_rmw_seq #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int txn_id = 0;
  logic [31:0] csr_mem [0:4095];
  logic [31:0] ref_mem [0:4095];

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  task automatic setCsr(input logic [11:0] a, input logic [31:0] v);
    csr_mem[a] = v;
    ref_mem[a] = v;
  endtask

  // Delays >= TO mean the bus never responds in that phase.
  task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] a,
                               input logic [31:0] rs1, input logic [4:0] zimm,
                               input logic [4:0] rd, input int rd_delay,
                               input int wr_delay, input int wb_delay);
    logic [1:0]  op;
    logic [31:0] src, old, exp_wdata, exp_data;
    logic [31:0] seen_addr, seen_waddr, seen_wdata, got_data;
    logic [31:0] got_rd, got_ill, got_err;
    bit illegal, wants_read, wants_write, exp_err, done;
    int exp_rd_cyc, exp_wr_cyc, exp_lat;
    int cyc, rd_cnt, wr_cnt, wb_cnt, lat, unstable, ready_hi;
    string p;

    txn_id++;
    p = $sformatf("t%0d_", txn_id);
    op          = f3[1:0];
    src         = f3[2] ? {27'b0, zimm} : rs1;
    illegal     = (op == 2'b00);
    wants_read  = !(op == 2'b01 && rd == 5'd0);
    wants_write = (op == 2'b01) || (src != 32'd0);
`ifdef CSR_RDONLY_CHECK_EN
    if (a[11:10] == 2'b11 && wants_write) illegal = 1'b1;
`endif
    exp_rd_cyc = 0; exp_wr_cyc = 0; exp_lat = 1;
    exp_err = 1'b0; old = 32'd0; exp_wdata = 32'd0;
    if (!illegal) begin
      if (wants_read) begin
        if (rd_delay >= TO) begin exp_err = 1'b1; exp_rd_cyc = TO; exp_lat += TO; end
        else begin exp_rd_cyc = rd_delay + 1; exp_lat += rd_delay + 1; old = ref_mem[a]; end
      end
      if (wants_write && !exp_err) begin
        case (op)
          2'b01:   exp_wdata = src;
          2'b10:   exp_wdata = old | src;
          default: exp_wdata = old & ~src;
        endcase
        if (wr_delay >= TO) begin exp_err = 1'b1; exp_wr_cyc = TO; exp_lat += TO; end
        else begin
          exp_wr_cyc = wr_delay + 1; exp_lat += wr_delay + 1; ref_mem[a] = exp_wdata;
        end
      end
    end
    exp_data = exp_err ? 32'd0 : old;

    @(negedge clk);
    checkOutput({p, "req_ready_idle"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1; bus.req_funct3 = f3; bus.req_addr = a;
    bus.req_rs1 = rs1; bus.req_zimm = zimm; bus.req_rd = rd;
    @(negedge clk);
    bus.req_valid = 1'b0; bus.req_funct3 = 3'($urandom); bus.req_addr = 12'($urandom);
    bus.req_rs1 = $urandom; bus.req_zimm = 5'($urandom); bus.req_rd = 5'($urandom);

    cyc = 1; rd_cnt = 0; wr_cnt = 0; wb_cnt = 0; lat = 0; unstable = 0; ready_hi = 0;
    done = 1'b0; seen_addr = 0; seen_waddr = 0; seen_wdata = 0;
    got_data = 0; got_rd = 0; got_ill = 0; got_err = 0;
    while (!done && cyc < 200) begin
      bus.csr_rvalid = 1'b0; bus.csr_wready = 1'b0; bus.wb_ready = 1'b0;
      if (bus.req_ready) ready_hi++;
      if (bus.csr_rd_en) begin
        rd_cnt++;
        if (rd_cnt == 1) seen_addr = 32'(bus.csr_addr);
        else if (32'(bus.csr_addr) !== seen_addr) unstable++;
        if (rd_cnt > rd_delay) begin
          bus.csr_rvalid = 1'b1; bus.csr_rdata = csr_mem[bus.csr_addr];
        end else bus.csr_rdata = $urandom;
      end
      if (bus.csr_wr_en) begin
        wr_cnt++;
        if (wr_cnt == 1) begin seen_wdata = bus.csr_wdata; seen_waddr = 32'(bus.csr_addr); end
        else if (bus.csr_wdata !== seen_wdata || 32'(bus.csr_addr) !== seen_waddr) unstable++;
        if (wr_cnt > wr_delay) begin
          bus.csr_wready = 1'b1; csr_mem[bus.csr_addr] = bus.csr_wdata;
        end
      end
      if (bus.wb_valid) begin
        wb_cnt++;
        if (wb_cnt == 1) begin
          lat = cyc; got_data = bus.wb_data; got_rd = 32'(bus.wb_rd);
          got_ill = 32'(bus.wb_illegal); got_err = 32'(bus.wb_buserr);
        end else if (bus.wb_data !== got_data || 32'(bus.wb_rd) !== got_rd ||
                     32'(bus.wb_illegal) !== got_ill || 32'(bus.wb_buserr) !== got_err)
          unstable++;
        if (wb_cnt > wb_delay) begin bus.wb_ready = 1'b1; done = 1'b1; end
      end
      @(negedge clk);
      cyc++;
    end
    bus.csr_rvalid = 1'b0; bus.csr_wready = 1'b0; bus.wb_ready = 1'b0;

    checkOutput({p, "completed"}, 32'(done), 32'd1);
    checkOutput({p, "wb_valid_drop"}, 32'(bus.wb_valid), 32'd0);
    checkOutput({p, "wb_rd"}, got_rd, 32'(rd));
    checkOutput({p, "wb_data"}, got_data, exp_data);
    checkOutput({p, "wb_illegal"}, got_ill, 32'(illegal));
    checkOutput({p, "wb_buserr"}, got_err, 32'(exp_err));
    checkOutput({p, "rd_cycles"}, 32'(rd_cnt), 32'(exp_rd_cyc));
    checkOutput({p, "wr_cycles"}, 32'(wr_cnt), 32'(exp_wr_cyc));
    checkOutput({p, "latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({p, "stable"}, 32'(unstable), 32'd0);
    checkOutput({p, "ready_low_busy"}, 32'(ready_hi), 32'd0);
    checkOutput({p, "csr_value"}, csr_mem[a], ref_mem[a]);
    if (exp_wr_cyc > 0) begin
      checkOutput({p, "wdata"}, seen_wdata, exp_wdata);
      checkOutput({p, "wr_addr"}, seen_waddr, 32'(a));
    end
    if (exp_rd_cyc > 0) checkOutput({p, "rd_addr"}, seen_addr, 32'(a));
  endtask

  task automatic resetMidWrite();
    setCsr(12'h340, 32'h5555_AAAA);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_funct3 = 3'b001; bus.req_addr = 12'h340;
    bus.req_rs1 = 32'hDEAD_BEEF; bus.req_zimm = 5'd0; bus.req_rd = 5'd0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_wr_en_before", 32'(bus.csr_wr_en), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_wr_en_async", 32'(bus.csr_wr_en), 32'd0);
    checkOutput("rst_rd_en_async", 32'(bus.csr_rd_en), 32'd0);
    checkOutput("rst_wb_valid_async", 32'(bus.wb_valid), 32'd0);
    checkOutput("rst_ready_async", 32'(bus.req_ready), 32'd1);
    #1 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      checkOutput("rst_no_wb_valid", 32'(bus.wb_valid), 32'd0);
      checkOutput("rst_no_wr_en", 32'(bus.csr_wr_en), 32'd0);
    end
    checkOutput("rst_csr_untouched", csr_mem[12'h340], 32'h5555_AAAA);
  endtask

  initial begin
    logic [11:0] addrs [6];
    logic [11:0] a;
    logic [31:0] rs1;
    logic [4:0]  zimm, rd;
    int rdd, wrd;

    addrs = '{12'h300, 12'h305, 12'h341, 12'hC00, 12'h7C0, 12'hC82};
    rst_n = 1'b1;
    bus.req_valid = 1'b0; bus.req_funct3 = 3'd0; bus.req_addr = 12'd0;
    bus.req_rs1 = 32'd0; bus.req_zimm = 5'd0; bus.req_rd = 5'd0;
    bus.csr_rdata = 32'd0; bus.csr_rvalid = 1'b0; bus.csr_wready = 1'b0;
    bus.wb_ready = 1'b0;
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = $urandom;
      ref_mem[i] = csr_mem[i];
    end

    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_rd_en", 32'(bus.csr_rd_en), 32'd0);
    checkOutput("reset_wr_en", 32'(bus.csr_wr_en), 32'd0);
    checkOutput("reset_wb_valid", 32'(bus.wb_valid), 32'd0);
    checkOutput("reset_wb_illegal", 32'(bus.wb_illegal), 32'd0);
    checkOutput("reset_wb_buserr", 32'(bus.wb_buserr), 32'd0);
    checkOutput("reset_csr_addr", 32'(bus.csr_addr), 32'd0);
    checkOutput("reset_csr_wdata", bus.csr_wdata, 32'd0);
    checkOutput("reset_wb_rd", 32'(bus.wb_rd), 32'd0);
    checkOutput("reset_wb_data", bus.wb_data, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_ready", 32'(bus.req_ready), 32'd1);

    // Directed cases first, then randomized traffic.
    setCsr(12'h340, 32'h0000_1234);
    applyStimulus(3'b001, 12'h340, 32'hA5A5_0000, 5'd0, 5'd3, 0, 0, 0);
    applyStimulus(3'b110, 12'h300, 32'hFFFF_FFFF, 5'd0, 5'd4, 0, 0, 0);
    setCsr(12'h341, 32'h0000_00FF);
    applyStimulus(3'b111, 12'h341, 32'd0, 5'd5, 5'd6, 0, 0, 0);
    applyStimulus(3'b001, 12'h305, 32'h1357_9BDF, 5'd0, 5'd0, 0, 0, 0);
    applyStimulus(3'b010, 12'h344, 32'h0000_0008, 5'd0, 5'd7, 100, 0, 0);
    applyStimulus(3'b100, 12'h300, 32'hFFFF_FFFF, 5'd9, 5'd8, 0, 0, 0);
    applyStimulus(3'b010, 12'h304, 32'h0000_0F00, 5'd0, 5'd9, 0, 0, 5);
    applyStimulus(3'b011, 12'h304, 32'h0000_0300, 5'd0, 5'd10, 1, 3, 0);
    applyStimulus(3'b001, 12'h7C0, 32'h0BAD_F00D, 5'd0, 5'd11, 0, 100, 2);
    applyStimulus(3'b001, 12'hC00, 32'h0000_0001, 5'd0, 5'd12, 0, 0, 0);
    applyStimulus(3'b010, 12'hC00, 32'd0, 5'd0, 5'd13, 0, 0, 0);
    resetMidWrite();

    for (int n = 0; n < 150; n++) begin
      a    = ($urandom_range(0, 3) == 0) ? 12'($urandom) : addrs[$urandom_range(0, 5)];
      rs1  = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      zimm = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd   = ($urandom_range(0, 4) == 0) ? 5'd0 : 5'($urandom);
      rdd  = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      wrd  = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(0, 3);
      applyStimulus(3'($urandom), a, rs1, zimm, rd, rdd, wrd, $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
